// File: rtl/data_mem_ctrl_if.sv
// Core <-> data-memory bus.
//   master: core side, drives rd/we/addr/wdata and observes rdata/rvalid/stall/err.
//   slave : memory side, the reverse.
interface data_mem_ctrl_if;
   logic        rd;
   logic        we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        rvalid;
   logic        stall;
   logic        err;

   modport master (output rd, we, addr, wdata, input rdata, rvalid, stall, err);
   modport slave  (input rd, we, addr, wdata, output rdata, rvalid, stall, err);
endinterface

// File: rtl/data_mem_ctrl.sv
// Multi-cycle data-memory responder for a single-cycle MIPS core.
// Accepts one load or store in IDLE, stalls the core for LATENCY cycles in total and
// completes in a single DONE cycle. The store commits there, or the load data and rvalid
// are presented there.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset; array contents are kept
//   bus  - slave modport: rd, we, addr, wdata in; rdata, rvalid, stall, err out
// Optional macro MISALIGN_TRAP_EN: a request with addr[1:0] != 0 is rejected with err.
module data_mem_ctrl #(
   parameter int unsigned DEPTH   = 256,
   parameter int unsigned ADDR_W  = 8,
   parameter int unsigned LATENCY = 2
) (
   input  logic          clk,
   input  logic          rst,
   data_mem_ctrl_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

   localparam logic [3:0] CntInit = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

   state_e              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic                op_we_q, op_we_d;
   logic                err_q, err_d;
   logic [ADDR_W-1:0]   idx_q, idx_d;
   logic [31:0]         wdata_q, wdata_d;
   logic [31:0]         rdata_q, rdata_d;
   logic [31:0]         mem [DEPTH];

   logic                req;
   logic                bad;
   logic                load_now;
   logic [ADDR_W-1:0]   idx_in;
   logic [ADDR_W-1:0]   idx_rd;
   logic                unused_addr;

   assign req    = bus.rd | bus.we;
   assign idx_in = bus.addr[ADDR_W+1:2];

`ifdef MISALIGN_TRAP_EN
   assign bad         = (bus.rd & bus.we) | (bus.addr[1:0] != 2'b00);
   assign unused_addr = ^bus.addr[31:ADDR_W+2];
`else
   assign bad         = bus.rd & bus.we;
   assign unused_addr = ^{bus.addr[31:ADDR_W+2], bus.addr[1:0]};
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_we_d  = op_we_q;
      err_d    = err_q;
      idx_d    = idx_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      idx_rd   = idx_q;
      load_now = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (req) begin
               op_we_d = bus.we;
               err_d   = bad;
               idx_d   = idx_in;
               wdata_d = bus.wdata;
               idx_rd  = idx_in;
               // Rejected requests skip the wait and report in the very next cycle.
               if (bad || LATENCY == 1) begin
                  state_d  = StDone;
                  load_now = ~bad & ~bus.we;
               end else begin
                  state_d = StWait;
                  cnt_d   = CntInit;
               end
            end
         end
         StWait: begin
            if (cnt_q == 4'd0) begin
               state_d  = StDone;
               load_now = ~op_we_q & ~err_q;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
      // Load data is registered on entry to DONE so it is stable for the rvalid cycle.
      if (load_now) rdata_d = mem[idx_rd];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         op_we_q <= 1'b0;
         err_q   <= 1'b0;
         idx_q   <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_we_q <= op_we_d;
         err_q   <= err_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   // Store commits on the edge that ends DONE; a reset in DONE drops it.
   always_ff @(posedge clk) begin
      if (!rst && state_q == StDone && op_we_q && !err_q) begin
         mem[idx_q] <= wdata_q;
      end
   end

   assign bus.rdata  = rdata_q;
   assign bus.rvalid = (state_q == StDone) & ~op_we_q & ~err_q;
   assign bus.err    = (state_q == StDone) & err_q;
   assign bus.stall  = ~rst & (((state_q == StIdle) & req) | (state_q == StWait));

endmodule

// File: tb/tb_data_mem_ctrl.sv
module tb_data_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        rd_drv, we_drv;
   logic [31:0] addr_drv, wdata_drv;
   int          sel;
   int          total = 0;
   int          bad = 0;
   int          pulses1 = 0;

   always #5 clk = ~clk;

   data_mem_ctrl_if if2 ();
   data_mem_ctrl_if if4 ();
   data_mem_ctrl_if if1 ();

   assign if2.rd = rd_drv & (sel == 0);
   assign if2.we = we_drv & (sel == 0);
   assign if2.addr = addr_drv;
   assign if2.wdata = wdata_drv;
   assign if4.rd = rd_drv & (sel == 1);
   assign if4.we = we_drv & (sel == 1);
   assign if4.addr = addr_drv;
   assign if4.wdata = wdata_drv;
   assign if1.rd = rd_drv & (sel == 2);
   assign if1.we = we_drv & (sel == 2);
   assign if1.addr = addr_drv;
   assign if1.wdata = wdata_drv;

   data_mem_ctrl #(.DEPTH(256), .ADDR_W(8), .LATENCY(2)) u_l2 (.clk(clk), .rst(rst), .bus(if2));
   data_mem_ctrl #(.DEPTH(256), .ADDR_W(8), .LATENCY(4)) u_l4 (.clk(clk), .rst(rst), .bus(if4));
   data_mem_ctrl #(.DEPTH(256), .ADDR_W(8), .LATENCY(1)) u_l1 (.clk(clk), .rst(rst), .bus(if1));

   logic [31:0] obs_rdata;
   logic        obs_rvalid, obs_stall, obs_err;

   always_comb begin
      obs_rdata  = if2.rdata;
      obs_rvalid = if2.rvalid;
      obs_stall  = if2.stall;
      obs_err    = if2.err;
      if (sel == 1) begin
         obs_rdata  = if4.rdata;
         obs_rvalid = if4.rvalid;
         obs_stall  = if4.stall;
         obs_err    = if4.err;
      end else if (sel == 2) begin
         obs_rdata  = if1.rdata;
         obs_rvalid = if1.rvalid;
         obs_stall  = if1.stall;
         obs_err    = if1.err;
      end
   end

   always @(posedge clk) if (if1.rvalid) pulses1 <= pulses1 + 1;

   typedef struct {
      logic [31:0] data;
      logic        is_load;
      logic        err;
      int          lat;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] mdl [3][256];

   function automatic int lat_of(int s);
      return (s == 0) ? 2 : (s == 1) ? 4 : 1;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      rd_drv = 1'b0;
      we_drv = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   // Called at a negedge; presents a request, holds it until DONE, returns at the next negedge.
   task automatic access(input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] d);
      exp_t        it;
      exp_t        got;
      logic [7:0]  idx;
      logic        rej;
      int          n_stall;
      bit          done;
      idx = a[9:2];
      rej = r & w;
`ifdef MISALIGN_TRAP_EN
      if (a[1:0] != 2'b00) rej = 1'b1;
`endif
      it.err     = rej;
      it.is_load = r & ~w & ~rej;
      it.data    = mdl[sel][idx];
      it.lat     = rej ? 1 : lat_of(sel);
      if (w && !rej) mdl[sel][idx] = d;
      sb.push_back(it);
      rd_drv = r;
      we_drv = w;
      addr_drv = a;
      wdata_drv = d;
      n_stall = 0;
      done = 1'b0;
      for (int i = 0; i < 24 && !done; i++) begin
         #1;
         if (i == 0) begin
            check("stall_accept", {31'd0, obs_stall}, 32'd1);
            check("no_early_rvalid", {31'd0, obs_rvalid | obs_err}, 32'd0);
         end else if (!obs_stall) begin
            done = 1'b1;
            got = sb.pop_front();
            check("latency", i, got.lat);
            check("stall_cycles", n_stall, got.lat);
            check("rvalid", {31'd0, obs_rvalid}, {31'd0, got.is_load});
            check("err", {31'd0, obs_err}, {31'd0, got.err});
            if (got.is_load) check("rdata", obs_rdata, got.data);
         end
         if (!done) begin
            if (obs_stall) n_stall++;
            @(negedge clk);
         end
      end
      if (!done) begin
         check("timeout", 32'd0, 32'd1);
         void'(sb.pop_front());
      end
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          p0;
      logic        seen;
      rst = 1'b1;
      sel = 0;
      rd_drv = 1'b0;
      we_drv = 1'b0;
      addr_drv = '0;
      wdata_drv = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_rvalid", {29'd0, if2.rvalid, if4.rvalid, if1.rvalid}, 32'd0);
      check("rst_err", {29'd0, if2.err, if4.err, if1.err}, 32'd0);
      check("rst_stall", {29'd0, if2.stall, if4.stall, if1.stall}, 32'd0);
      check("rst_rdata2", if2.rdata, 32'd0);
      check("rst_rdata4", if4.rdata, 32'd0);
      check("rst_rdata1", if1.rdata, 32'd0);
      @(negedge clk);

      // Store then load, LATENCY=2
      access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
      idle(1);
      access(1'b1, 1'b0, 32'h10, 32'h0);
      idle(1);

      // Address wrap
      access(1'b0, 1'b1, 32'h400, 32'h12345678);
      access(1'b1, 1'b0, 32'h000, 32'h0);
      access(1'b0, 1'b1, 32'h7FC, 32'hCAFEF00D);
      access(1'b1, 1'b0, 32'hFFC, 32'h0);
      idle(1);

      // Illegal rd=we=1 leaves memory alone
      access(1'b0, 1'b1, 32'h20, 32'h55AA55AA);
      access(1'b1, 1'b1, 32'h20, 32'h99999999);
      access(1'b1, 1'b0, 32'h20, 32'h0);
      idle(1);

      // Misaligned load
      access(1'b0, 1'b1, 32'h50, 32'h0BADCAFE);
      access(1'b1, 1'b0, 32'h52, 32'h0);
      idle(1);

      // Reset during WAIT abandons the store, LATENCY=4
      sel = 1;
      access(1'b0, 1'b1, 32'h30, 32'h11111111);
      idle(1);
      rd_drv = 1'b0;
      we_drv = 1'b1;
      addr_drv = 32'h30;
      wdata_drv = 32'hAAAAAAAA;
      repeat (2) @(negedge clk);
      #1;
      check("stall_wait", {31'd0, obs_stall}, 32'd1);
      rst = 1'b1;
      #1;
      check("stall_in_rst", {31'd0, obs_stall}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      we_drv = 1'b0;
      #1;
      check("post_rst_rvalid", {31'd0, obs_rvalid}, 32'd0);
      check("post_rst_stall", {31'd0, obs_stall}, 32'd0);
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         #1;
         if (obs_rvalid || obs_err || obs_stall) seen = 1'b1;
      end
      check("post_rst_quiet", {31'd0, seen}, 32'd0);
      @(negedge clk);
      access(1'b1, 1'b0, 32'h30, 32'h0);
      idle(1);

      // Back-to-back loads, LATENCY=1
      sel = 2;
      access(1'b0, 1'b1, 32'h40, 32'h40404040);
      access(1'b0, 1'b1, 32'h44, 32'h44444444);
      idle(2);
      p0 = pulses1;
      access(1'b1, 1'b0, 32'h40, 32'h0);
      access(1'b1, 1'b0, 32'h44, 32'h0);
      idle(3);
      check("rvalid_pulses", pulses1 - p0, 32'd2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
